// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES-wide signed multiply-accumulate engine with a three-stage pipeline.
// Each lane computes pixel * weight. On the first beat of a group the lane is seeded with the
// bias, and the group total is emitted on the last beat.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset (wins over en)
//   en                  pipeline clock enable; 0 freezes every register
//   in_valid            beat qualifier for pixel_in/weight_in/in_first/in_last
//   in_first, in_last   group delimiters
//   pixel_in            LANES x A_W signed, lane i at [i*A_W +: A_W]
//   weight_in           LANES x B_W signed, lane i at [i*B_W +: B_W]
//   bias_in             LANES x ACC_W signed, sampled on valid first beats only
//   out_valid           one-cycle pulse when data_out holds a new group total
//   data_out            LANES x ACC_W group totals, held between pulses
//   sat_out             per-lane clamp flag for the emitted group
//
// Optional feature: define MAC_SAT_EN for saturating accumulation and sticky per-lane
// saturation flags. Without it, arithmetic wraps modulo 2^ACC_W and sat_out is 0.
module mac_lane_array #(
  parameter int unsigned LANES = 8,
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*A_W-1:0]   pixel_in,
  input  logic [LANES*B_W-1:0]   weight_in,
  input  logic [LANES*ACC_W-1:0] bias_in,
  output logic                   out_valid,
  output logic [LANES*ACC_W-1:0] data_out,
  output logic [LANES-1:0]       sat_out
);

  localparam int unsigned P_W = A_W + B_W;

  // S1: registered operands
  logic                   s1_valid, s1_first, s1_last;
  logic [LANES*A_W-1:0]   s1_pixel;
  logic [LANES*B_W-1:0]   s1_weight;
  logic [LANES*ACC_W-1:0] s1_bias;
  // S2: sign-extended products
  logic                   s2_valid, s2_first, s2_last;
  logic [LANES*ACC_W-1:0] s2_prod, s2_bias;
  // S3: accumulators and outputs
  logic [LANES*ACC_W-1:0] acc_q, data_out_q;
  logic                   out_valid_q;

  logic [LANES*ACC_W-1:0] prod_d, acc_d;

`ifdef MAC_SAT_EN
  logic [LANES-1:0] flag_q, flag_d, sat_q;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [A_W-1:0]   a;
    logic signed [B_W-1:0]   b;
    logic signed [P_W-1:0]   p;
    logic signed [ACC_W-1:0] base, prod, sum;

    assign a = s1_pixel[g*A_W +: A_W];
    assign b = s1_weight[g*B_W +: B_W];
    assign p = P_W'(a) * P_W'(b);
    assign prod_d[g*ACC_W +: ACC_W] = ACC_W'(p);

    // A first beat reseeds from bias, which drops any open partial sum.
    assign base = s2_first ? s2_bias[g*ACC_W +: ACC_W] : acc_q[g*ACC_W +: ACC_W];
    assign prod = s2_prod[g*ACC_W +: ACC_W];

`ifdef MAC_SAT_EN
    logic signed [ACC_W:0] wide;
    logic                  clamp;
    // Overflow occurs when the extra sign bit disagrees with the ACC_W-bit result sign.
    assign wide  = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
    assign clamp = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum   = !clamp     ? wide[ACC_W-1:0] :
                   wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign flag_d[g] = (s2_first ? 1'b0 : flag_q[g]) | clamp;
`else
    assign sum = base + prod;
`endif

    assign acc_d[g*ACC_W +: ACC_W] = sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_pixel    <= '0;
      s1_weight   <= '0;
      s1_bias     <= '0;
      s2_valid    <= 1'b0;
      s2_first    <= 1'b0;
      s2_last     <= 1'b0;
      s2_prod     <= '0;
      s2_bias     <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_first  <= in_valid & in_first;
      s1_last   <= in_valid & in_last;
      s1_pixel  <= pixel_in;
      s1_weight <= weight_in;
      if (in_valid && in_first) s1_bias <= bias_in;
      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_prod   <= prod_d;
      s2_bias   <= s1_bias;
      out_valid_q <= s2_valid & s2_last;
      if (s2_valid) begin
        acc_q <= acc_d;
        if (s2_last) data_out_q <= acc_d;
      end
    end
  end

`ifdef MAC_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= '0;
      sat_q  <= '0;
    end else if (en && s2_valid) begin
      flag_q <= flag_d;
      if (s2_last) sat_q <= flag_d;
    end
  end
  assign sat_out = sat_q;
`else
  assign sat_out = '0;
`endif

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_mac_lane_array.sv
// Testbench for mac_lane_array. It compares the DUT with a behavioural model that uses
// integer arithmetic. Expected results are queued with the enabled-edge count at which
// each one must appear.
module tb_mac_lane_array;

  localparam int LANES = 8;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 32;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic                   clk = 1'b0;
  logic                   rst_n, en, in_valid, in_first, in_last;
  logic [LANES*A_W-1:0]   pixel_in;
  logic [LANES*B_W-1:0]   weight_in;
  logic [LANES*ACC_W-1:0] bias_in;
  logic                   out_valid;
  logic [LANES*ACC_W-1:0] data_out;
  logic [LANES-1:0]       sat_out;

  mac_lane_array #(
    .LANES (LANES),
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .pixel_in  (pixel_in),
    .weight_in (weight_in),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .sat_out   (sat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     due;
    logic [LANES*ACC_W-1:0] data;
    logic [LANES-1:0]       sat;
  } exp_t;

  exp_t   q[$];
  int     pix [LANES];
  int     wt  [LANES];
  longint bias[LANES];
  longint acc [LANES];
  bit     flag[LANES];
  int     en_edges = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  logic                   exp_ov   = 1'b0;
  logic [LANES*ACC_W-1:0] exp_data = '0;
  logic [LANES-1:0]       exp_sat  = '0;

  task automatic drive_ops();
    for (int i = 0; i < LANES; i++) begin
      pixel_in[i*A_W +: A_W]   = pix[i][A_W-1:0];
      weight_in[i*B_W +: B_W]  = wt[i][B_W-1:0];
      bias_in[i*ACC_W +: ACC_W] = bias[i][ACC_W-1:0];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < LANES; i++) begin
      pix[i] = int'($urandom_range(255)) - 128;
      wt[i]  = int'($urandom_range(255)) - 128;
      case ($urandom_range(3))
        0:       bias[i] = ACC_MAX - longint'($urandom_range(20000));
        1:       bias[i] = ACC_MIN + longint'($urandom_range(20000));
        default: bias[i] = longint'(int'($urandom()));
      endcase
    end
  endtask

  task automatic set_all(input int p, input int w, input longint b);
    for (int i = 0; i < LANES; i++) begin
      pix[i]  = p;
      wt[i]   = w;
      bias[i] = b;
    end
  endtask

  // Model the spec rules. A beat takes effect when it is sampled. A last beat schedules its
  // totals two enabled edges later.
  task automatic model_beat(input bit f, input bit l);
    exp_t e;
    for (int i = 0; i < LANES; i++) begin
      longint s;
      bit     c;
      c = 1'b0;
      s = (f ? bias[i] : acc[i]) + longint'(pix[i]) * longint'(wt[i]);
`ifdef MAC_SAT_EN
      if (s > ACC_MAX) begin
        s = ACC_MAX;
        c = 1'b1;
      end else if (s < ACC_MIN) begin
        s = ACC_MIN;
        c = 1'b1;
      end
      flag[i] = (f ? 1'b0 : flag[i]) | c;
`else
      s = longint'(int'(s));
      flag[i] = c;
`endif
      acc[i] = s;
      e.data[i*ACC_W +: ACC_W] = s[ACC_W-1:0];
      e.sat[i] = flag[i];
    end
    if (l) begin
      e.due = en_edges + 2;
      q.push_back(e);
    end
  endtask

  task automatic check();
    n_cmp++;
    assert (out_valid === exp_ov) else begin
      n_bad++;
      $error("FAIL out_valid: got %b want %b (en_edge %0d)", out_valid, exp_ov, en_edges);
    end
    n_cmp++;
    assert (data_out === exp_data) else begin
      n_bad++;
      $error("FAIL data_out: got %h want %h", data_out, exp_data);
    end
    n_cmp++;
    assert (sat_out === exp_sat) else begin
      n_bad++;
      $error("FAIL sat_out: got %b want %b", sat_out, exp_sat);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step(input bit e, input bit v, input bit f, input bit l);
    en       = e;
    in_valid = v;
    in_first = f;
    in_last  = l;
    drive_ops();
    @(posedge clk);
    #1;
    if (e) begin
      en_edges++;
      if (q.size() > 0 && q[0].due == en_edges) begin
        exp_ov   = 1'b1;
        exp_data = q[0].data;
        exp_sat  = q[0].sat;
        void'(q.pop_front());
      end else begin
        exp_ov = 1'b0;
      end
      if (v) model_beat(f, l);
    end
    check();
  endtask

  task automatic do_reset(input int n, input bit e);
    rst_n    = 1'b0;
    en       = e;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q.delete();
    for (int i = 0; i < LANES; i++) begin
      acc[i]  = 0;
      flag[i] = 1'b0;
    end
    exp_ov   = 1'b0;
    exp_data = '0;
    exp_sat  = '0;
    check();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    pixel_in = '0; weight_in = '0; bias_in = '0;
    set_all(0, 0, 0);

    // Reset held for two cycles.
    do_reset(2, 1'b1);

    // Single-beat group: lane0 3 * -4 + 10.
    rand_ops();
    pix[0] = 3; wt[0] = -4; bias[0] = 10;
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    chk("single_early", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_lane0", data_out[31:0], 32'hFFFF_FFFE);
    step(1, 0, 0, 0);
    chk("single_width", {31'd0, out_valid}, 32'd0);

    // Four beats of 127*127 with a bubble.
    set_all(127, 127, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("grp4_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < LANES; i++) chk("grp4_lane", data_out[i*ACC_W +: ACC_W], 32'd64516);
    step(1, 0, 0, 0);
    chk("grp4_width", {31'd0, out_valid}, 32'd0);

    // Same group with en held low for five cycles mid-group and two before the output.
    set_all(127, 127, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step(0, 1, k[0], 1);
    end
    set_all(127, 127, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("en_gap_early", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("en_gap_valid", {31'd0, out_valid}, 32'd1);
    chk("en_gap_lane0", data_out[31:0], 32'd64516);
    step(0, 0, 0, 0);
    chk("en_gap_hold", {31'd0, out_valid}, 32'd1);
    step(1, 0, 0, 0);

    // Lane independence: lane i pixel i, weight -128, bias i.
    for (int i = 0; i < LANES; i++) begin
      pix[i] = i; wt[i] = -128; bias[i] = longint'(i);
    end
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < LANES; i++) begin
      int want;
      want = -127 * i;
      chk("lanes", data_out[i*ACC_W +: ACC_W], want);
    end

    // Overflow near the positive limit.
    set_all(127, 127, 0);
    bias[0] = 64'sh7FFF_FFF0;
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
`ifdef MAC_SAT_EN
    chk("ovf_lane0", data_out[31:0], 32'h7FFF_FFFF);
    chk("ovf_sat0", {31'd0, sat_out[0]}, 32'd1);
`else
    chk("ovf_lane0", data_out[31:0], 32'h8000_3EF1);
    chk("ovf_sat0", {31'd0, sat_out[0]}, 32'd0);
`endif

    // Reset mid-group with en low. The next output covers only post-reset beats.
    rand_ops();
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    do_reset(1, 1'b0);
    rand_ops();
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Back-to-back single-beat groups.
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      step(1, 1, 1, 1);
    end

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      rand_ops();
      step($urandom_range(3) != 0, $urandom_range(9) < 7, $urandom_range(9) < 2,
           $urandom_range(9) < 2);
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
